oled_mode_scheduler: RTL and testbench

Schedules and serialises operation requests to the SSD1331 OLED interface controller. It sits between the user-facing request sources and the OLED interface: buttons, switch logic, and the text/colour update logic. Four request lines are latched, arbitrated by fixed priority and gated by the panel power state. The block issues exactly one `i_MODE`/`i_START` transaction at a time and waits for the interface's READY handshake. A watchdog reports stuck transactions.

---
 rtl/oled_mode_scheduler.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_oled_mode_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_mode_scheduler.sv
// -----------------------------------------------------------------------------
// oled_mode_scheduler
//
// Serialises operation requests towards the SSD1331 OLED interface controller.
// Four request lines are latched into a pending set. Requests are arbitrated by
// fixed priority (0 > 3 > 1 > 2) and gated by the panel power state. Exactly one
// START/MODE transaction is outstanding at a time, and completion is tracked
// through the interface's READY handshake. A watchdog aborts a transaction
// whose READY never returns high and raises a sticky error flag.
//
// Optional feature macro: OLED_SCHED_AUTO_REDRAW_EN
//   defined   : while powered, a change of i_BG_COLOR against a registered copy
//               queues a colour-fill request (bit 2).
//   undefined : colour changes only take effect through an explicit i_REQ[2].
//
// Ports
//   i_CLK       system clock, rising edge
//   i_RST       synchronous reset, active low
//   i_REQ[3:0]  request pulses/levels: 0 power-on, 1 draw text,
//               2 colour fill, 3 power-off
//   o_ACK[3:0]  one-cycle completion pulse per request bit
//   i_READY     READY from the OLED interface
//   o_MODE[1:0] mode to the OLED interface (granted request bit index)
//   o_START     one-cycle start pulse to the OLED interface
//   i_BG_COLOR  requested background colour
//   o_BG_COLOR  colour frozen at issue, held until the next issue
//   o_BUSY      high from grant until the ACK/abort cycle inclusive
//   o_POWERED   panel power state
//   o_ERR       sticky timeout flag
// -----------------------------------------------------------------------------
module oled_mode_scheduler #(
    parameter int TIMEOUT_CYCLES   = 4000000,
    parameter int BUSY_WAIT_CYCLES = 16,
    parameter int N_COLOR_BITS     = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [3:0]              i_REQ,
    output logic [3:0]              o_ACK,
    input  logic                    i_READY,
    output logic [1:0]              o_MODE,
    output logic                    o_START,
    input  logic [N_COLOR_BITS-1:0] i_BG_COLOR,
    output logic [N_COLOR_BITS-1:0] o_BG_COLOR,
    output logic                    o_BUSY,
    output logic                    o_POWERED,
    output logic                    o_ERR
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW_W = $clog2(BUSY_WAIT_CYCLES + 1);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [BW_W-1:0] BW_LAST = BW_W'(BUSY_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_FALL = 3'd2,
        WAIT_RISE = 3'd3,
        DONE      = 3'd4,
        ABORT     = 3'd5
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [3:0]              pending_reg;
    logic [3:0]              pending_next;
    logic [1:0]              cur_idx_reg;
    logic [1:0]              mode_reg;
    logic [N_COLOR_BITS-1:0] bg_reg;
    logic [3:0]              ack_reg;
    logic                    powered_reg;
    logic                    err_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [BW_W-1:0]         busy_cnt_reg;

    logic [3:0]              issue_ok;
    logic [3:0]              noop_ok;
    logic [3:0]              cand;
    logic                    sel_valid;
    logic [1:0]              sel_idx;
    logic                    sel_noop;
    logic                    grant_issue;
    logic                    grant_noop;
    logic [3:0]              clr_mask;
    logic [3:0]              redraw_set;
    logic [3:0]              ack_set;

    // -------------------------------------------------------------------------
    // Per-bit eligibility. Power-on is only a real operation when unpowered,
    // power-off only when powered; the opposite case completes as a no-op.
    // Draw/fill need the panel powered and otherwise just stay queued.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_elig
        if (gi == 0) begin : g_power_on
            assign issue_ok[gi] = pending_reg[gi] & ~powered_reg;
            assign noop_ok[gi]  = pending_reg[gi] &  powered_reg;
        end else if (gi == 3) begin : g_power_off
            assign issue_ok[gi] = pending_reg[gi] &  powered_reg;
            assign noop_ok[gi]  = pending_reg[gi] & ~powered_reg;
        end else begin : g_draw
            assign issue_ok[gi] = pending_reg[gi] &  powered_reg;
            assign noop_ok[gi]  = 1'b0;
        end
    end

    assign cand = issue_ok | noop_ok;

    // Fixed priority 0 > 3 > 1 > 2 across real and no-op candidates alike.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        if (cand[0]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd0;
        end else if (cand[3]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd3;
        end else if (cand[1]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd1;
        end else if (cand[2]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'd2;
        end
    end

    assign sel_noop = noop_ok[sel_idx];

    // A no-op completes without touching the interface, so it does not wait
    // for READY; a real grant stalls in IDLE until READY is high.
    assign grant_noop  = (state_reg == IDLE) && sel_valid && sel_noop;
    assign grant_issue = (state_reg == IDLE) && sel_valid && !sel_noop && i_READY;
    assign clr_mask    = (grant_noop || grant_issue) ? (4'b0001 << sel_idx) : 4'b0000;

    // -------------------------------------------------------------------------
    // Automatic redraw on background colour change.
    // -------------------------------------------------------------------------
`ifdef OLED_SCHED_AUTO_REDRAW_EN
    logic [N_COLOR_BITS-1:0] bg_copy_reg;

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            bg_copy_reg <= '0;
        end else begin
            bg_copy_reg <= i_BG_COLOR;
        end
    end

    assign redraw_set = {1'b0, powered_reg && (i_BG_COLOR != bg_copy_reg), 2'b00};
`else
    assign redraw_set = 4'b0000;
`endif

    // Set after clear: a request arriving on its own grant cycle is re-queued.
    assign pending_next = (pending_reg & ~clr_mask) | i_REQ | redraw_set;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
        assign ack_set[gi] = (state_reg == DONE) && (cur_idx_reg == 2'(gi));
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_noop) begin
                    state_next = DONE;
                end else if (grant_issue) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_FALL;
            end
            WAIT_FALL: begin
                // READY never dropping within the window counts as completion.
                if (!i_READY) begin
                    state_next = WAIT_RISE;
                end else if (busy_cnt_reg == BW_LAST) begin
                    state_next = DONE;
                end
            end
            WAIT_RISE: begin
                if (i_READY) begin
                    state_next = DONE;
                end else if (to_cnt_reg >= TO_LAST) begin
                    state_next = ABORT;
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        o_START = (state_reg == ISSUE);
        // The ACK pulse lands in the IDLE cycle after DONE; keep BUSY up for it.
        o_BUSY  = (state_reg != IDLE) || (ack_reg != 4'b0000);
    end

    // -------------------------------------------------------------------------
    // Datapath: pending set, issue latches, counters, status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            pending_reg  <= 4'b0000;
            cur_idx_reg  <= 2'd0;
            mode_reg     <= 2'd0;
            bg_reg       <= '0;
            ack_reg      <= 4'b0000;
            powered_reg  <= 1'b0;
            err_reg      <= 1'b0;
            to_cnt_reg   <= '0;
            busy_cnt_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            ack_reg     <= ack_set;

            if (grant_noop || grant_issue) begin
                cur_idx_reg <= sel_idx;
            end

            // MODE and colour are only refreshed by a real issue.
            if (grant_issue) begin
                mode_reg <= sel_idx;
                bg_reg   <= i_BG_COLOR;
            end

            // Watchdog runs from the ISSUE cycle onward and saturates.
            if (state_reg == IDLE) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg != TO_MAX) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end

            if (state_reg == WAIT_FALL) begin
                busy_cnt_reg <= busy_cnt_reg + BW_W'(1);
            end else begin
                busy_cnt_reg <= '0;
            end

            if (state_reg == DONE) begin
                if (cur_idx_reg == 2'd0) begin
                    powered_reg <= 1'b1;
                end else if (cur_idx_reg == 2'd3) begin
                    powered_reg <= 1'b0;
                end
            end

            if (state_reg == ABORT) begin
                err_reg     <= 1'b1;
                powered_reg <= 1'b0;
            end
        end
    end

    assign o_ACK      = ack_reg;
    assign o_MODE     = mode_reg;
    assign o_BG_COLOR = bg_reg;
    assign o_POWERED  = powered_reg;
    assign o_ERR      = err_reg;

endmodule

// File: tb/tb_oled_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_oled_mode_scheduler
//
// Directed bench for oled_mode_scheduler. A small READY stub answers START
// pulses (normal handshake, never dropping, or dropping forever). A monitor
// logs every START and ACK with the cycle number so sequences can check exact
// latencies. A table of single-request scenarios covers arbitration and power
// gating; hand-written sequences cover reset, latencies, timeout, busy-wait
// completion with re-queue, mid-transaction reset and colour handling.
// -----------------------------------------------------------------------------
module tb_oled_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic       ready = 1'b1;
    logic [1:0] mode;
    logic       start;
    logic [7:0] bg_in = 8'h00;
    logic [7:0] bg_out;
    logic       busy;
    logic       powered;
    logic       err;

    always #5 clk = ~clk;

    oled_mode_scheduler #(
        .TIMEOUT_CYCLES  (50),
        .BUSY_WAIT_CYCLES(16),
        .N_COLOR_BITS    (8)
    ) dut (
        .i_CLK     (clk),
        .i_RST     (rst_n),
        .i_REQ     (req),
        .o_ACK     (ack),
        .i_READY   (ready),
        .o_MODE    (mode),
        .o_START   (start),
        .i_BG_COLOR(bg_in),
        .o_BG_COLOR(bg_out),
        .o_BUSY    (busy),
        .o_POWERED (powered),
        .o_ERR     (err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // READY stub: 0 = drop for two cycles after START, 1 = never drop,
    // 2 = drop and never restore.
    int stub_mode = 0;
    int low_cnt   = 0;
    always @(negedge clk) begin
        if (start) begin
            if (stub_mode == 0) begin
                ready   = 1'b0;
                low_cnt = 1;
            end else if (stub_mode == 2) begin
                ready = 1'b0;
            end
        end else if (stub_mode == 0) begin
            if (low_cnt > 0) begin
                ready   = 1'b0;
                low_cnt = low_cnt - 1;
            end else begin
                ready = 1'b1;
            end
        end
    end

    // Transaction monitor.
    int         start_cyc[$];
    logic [1:0] start_mode[$];
    logic [7:0] start_bg[$];
    logic       start_busy[$];
    int         ack_cyc[$];
    logic [3:0] ack_val[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (start) begin
                start_cyc.push_back(cyc);
                start_mode.push_back(mode);
                start_bg.push_back(bg_out);
                start_busy.push_back(busy);
                $display("[%0d] START mode=%0d bg=%02h", cyc, mode, bg_out);
            end
            if (ack != 4'b0000) begin
                ack_cyc.push_back(cyc);
                ack_val.push_back(ack);
                $display("[%0d] ACK %b", cyc, ack);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stub_mode = 0;
        req       = 4'b0000;
        rst_n     = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        tick(1);
        req = 4'b0000;
    endtask

    task automatic power_up();
        pulse_req(4'b0001);
        tick(12);
    endtask

    function automatic int sc(input int idx);
        return (idx < start_cyc.size()) ? start_cyc[idx] : -1;
    endfunction

    function automatic int smode(input int idx);
        return (idx < start_mode.size()) ? int'(start_mode[idx]) : -1;
    endfunction

    function automatic int ac(input int idx);
        return (idx < ack_cyc.size()) ? ack_cyc[idx] : -1;
    endfunction

    function automatic logic [3:0] acks_since(input int base);
        logic [3:0] r;
        r = 4'b0000;
        for (int j = base; j < ack_val.size(); j++) r = r | ack_val[j];
        return r;
    endfunction

    typedef struct {
        logic       pwr;
        logic [3:0] rq;
        int         n_start;
        logic [1:0] first_mode;
        logic [3:0] ack_or;
        logic       pwr_after;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int sb, ab, k, e, ns;

        tbl[0]  = '{1'b0, 4'b0010, 0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 0, 2'd0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1000, 0, 2'd0, 4'b1000, 1'b0};
        tbl[3]  = '{1'b0, 4'b0001, 1, 2'd0, 4'b0001, 1'b1};
        tbl[4]  = '{1'b0, 4'b0011, 2, 2'd0, 4'b0011, 1'b1};
        tbl[5]  = '{1'b1, 4'b0001, 0, 2'd0, 4'b0001, 1'b1};
        tbl[6]  = '{1'b1, 4'b0010, 1, 2'd1, 4'b0010, 1'b1};
        tbl[7]  = '{1'b1, 4'b0100, 1, 2'd2, 4'b0100, 1'b1};
        tbl[8]  = '{1'b1, 4'b1000, 1, 2'd3, 4'b1000, 1'b0};
        tbl[9]  = '{1'b1, 4'b1110, 1, 2'd3, 4'b1000, 1'b0};
        tbl[10] = '{1'b1, 4'b0110, 2, 2'd1, 4'b0110, 1'b1};
        tbl[11] = '{1'b0, 4'b1001, 2, 2'd0, 4'b1001, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 2, 2'd0, 4'b1001, 1'b0};

        // Reset values.
        tick(2);
        chk("rst ack", ack, 4'b0000);
        chk("rst mode", mode, 2'd0);
        chk("rst start", start, 1'b0);
        chk("rst bg", bg_out, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst powered", powered, 1'b0);
        chk("rst err", err, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Arbitration / power-gating table.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            if (tbl[i].pwr) power_up();
            sb = start_cyc.size();
            ab = ack_cyc.size();
            pulse_req(tbl[i].rq);
            tick(40);
            ns = start_cyc.size() - sb;
            chk($sformatf("v%0d n_start", i), ns, tbl[i].n_start);
            if (tbl[i].n_start > 0)
                chk($sformatf("v%0d first_mode", i), smode(sb), tbl[i].first_mode);
            chk($sformatf("v%0d ack_or", i), acks_since(ab), tbl[i].ack_or);
            chk($sformatf("v%0d powered", i), powered, tbl[i].pwr_after);
        end

        // Draw held off while unpowered, then power-on and automatic draw.
        do_reset();
        sb = start_cyc.size();
        ab = ack_cyc.size();
        pulse_req(4'b0010);
        tick(10);
        chk("seqB draw held", start_cyc.size() - sb, 0);
        pulse_req(4'b0001);
        k = cyc;
        tick(14);
        chk("seqB start0 cyc", sc(sb), k + 1);
        chk("seqB start0 mode", smode(sb), 0);
        chk("seqB busy at start", (sb < start_busy.size()) ? start_busy[sb] : 1'b0, 1'b1);
        chk("seqB ack0 cyc", ac(ab), k + 5);
        chk("seqB ack0 val", (ab < ack_val.size()) ? ack_val[ab] : 4'b0000, 4'b0001);
        chk("seqB start1 cyc", sc(sb + 1), k + 6);
        chk("seqB start1 mode", smode(sb + 1), 1);
        chk("seqB powered", powered, 1'b1);

        // No-op power-on while powered.
        do_reset();
        power_up();
        sb = start_cyc.size();
        ab = ack_cyc.size();
        pulse_req(4'b0001);
        k = cyc;
        tick(10);
        chk("noop on ack cyc", ac(ab), k + 2);
        chk("noop on ack cnt", ack_cyc.size() - ab, 1);
        chk("noop on starts", start_cyc.size() - sb, 0);

        // No-op power-off while unpowered.
        do_reset();
        sb = start_cyc.size();
        ab = ack_cyc.size();
        pulse_req(4'b1000);
        k = cyc;
        tick(10);
        chk("noop off ack cyc", ac(ab), k + 2);
        chk("noop off ack val", acks_since(ab), 4'b1000);
        chk("noop off starts", start_cyc.size() - sb, 0);

        // Watchdog timeout.
        do_reset();
        power_up();
        stub_mode = 2;
        sb = start_cyc.size();
        ab = ack_cyc.size();
        pulse_req(4'b0010);
        k = cyc;
        e = k + 1;
        tick(50);
        chk("to start cyc", sc(sb), e);
        chk("to err early", err, 1'b0);
        tick(2);
        chk("to err set", err, 1'b1);
        chk("to powered", powered, 1'b0);
        chk("to no ack", ack_cyc.size() - ab, 0);
        stub_mode = 0;
        tick(5);
        chk("to err sticky", err, 1'b1);
        do_reset();
        chk("to err cleared", err, 1'b0);

        // READY never drops: busy-wait completion plus re-queue of held request.
        do_reset();
        power_up();
        stub_mode = 1;
        sb = start_cyc.size();
        ab = ack_cyc.size();
        pulse_req(4'b0010);
        k = cyc;
        tick(4);
        req = 4'b0010;
        tick(3);
        req = 4'b0000;
        tick(50);
        chk("bw ack latency", ac(ab) - sc(sb), 18);
        chk("bw ack val", (ab < ack_val.size()) ? ack_val[ab] : 4'b0000, 4'b0010);
        chk("bw start count", start_cyc.size() - sb, 2);
        chk("bw requeue mode", smode(sb + 1), 1);
        stub_mode = 0;

        // Reset in the middle of a transaction.
        do_reset();
        power_up();
        stub_mode = 1;
        ab = ack_cyc.size();
        pulse_req(4'b0100);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("midrst start", start, 1'b0);
        chk("midrst busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(30);
        chk("midrst no ack", ack_cyc.size() - ab, 0);
        chk("midrst powered", powered, 1'b0);
        stub_mode = 0;

        // Background colour handling.
        do_reset();
        power_up();
        sb = start_cyc.size();
        bg_in = 8'hE0;
        tick(12);
`ifdef OLED_SCHED_AUTO_REDRAW_EN
        chk("color auto starts", start_cyc.size() - sb, 1);
        chk("color auto mode", smode(sb), 2);
        chk("color auto bg", (sb < start_bg.size()) ? start_bg[sb] : 8'h00, 8'hE0);
`else
        chk("color no auto", start_cyc.size() - sb, 0);
        bg_in = 8'h5A;
        sb = start_cyc.size();
        pulse_req(4'b0100);
        tick(1);
        bg_in = 8'h33;
        tick(12);
        chk("color req start", start_cyc.size() - sb, 1);
        chk("color frozen at issue", (sb < start_bg.size()) ? start_bg[sb] : 8'h00, 8'h5A);
        chk("color held after", bg_out, 8'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
